// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//
// Memory-side responder for the data cache's physical-memory line port.
// Accepts one cache-line read or write, runs it as a BEATS-long burst on
// the main-memory bus, then pulses line_resp for one cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   line_read      cache line read request (held until line_resp)
//   line_write     cache line write request (held until line_resp)
//   line_address   line address; offset bits are dropped on acceptance
//   line_wdata     line to write
//   line_rdata     last assembled read line
//   line_resp      single-cycle completion pulse
//   burst_read     memory burst read strobe
//   burst_write    memory burst write strobe
//   burst_address  line-aligned burst address (latched)
//   burst_wdata    current write beat
//   burst_rdata    read beat, valid while burst_resp is high
//   burst_resp     one beat transferred this cycle
module line_burst_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [31:0]            line_address,
    input  logic [LINE_WIDTH-1:0]  line_wdata,
    output logic [LINE_WIDTH-1:0]  line_rdata,
    output logic                   line_resp,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [31:0]            burst_address,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_BURST = 2'd1;
    localparam logic [1:0] S_WR_BURST = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [31:0]           addr_reg, addr_next;
    logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;

    logic in_burst;
    logic last_beat;

    assign in_burst  = (state_reg == S_RD_BURST) || (state_reg == S_WR_BURST);
    assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            S_IDLE: begin
                // Read has priority; a simultaneous write is not captured.
                if (line_read) begin
                    addr_next  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_next   = '0;
                    state_next = S_RD_BURST;
                end else if (line_write) begin
                    addr_next  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    wdata_next = line_wdata;
                    cnt_next   = '0;
                    state_next = S_WR_BURST;
                end
            end
            S_RD_BURST, S_WR_BURST: begin
                if (burst_resp) begin
                    // Counter is exactly log2(BEATS) wide, so it wraps to 0
                    // on the last beat by itself.
                    cnt_next = cnt_reg + 1'b1;
                    if (last_beat) begin
                        state_next = S_RESP;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Per-beat slices: write beats are views of the latched line, read
    // beats are individually captured registers.
    logic [BURST_WIDTH-1:0] wbeat [BEATS];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BURST_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg <= '0;
                end else if ((state_reg == S_RD_BURST) && burst_resp &&
                             (cnt_reg == CNT_W'(gi))) begin
                    slot_reg <= burst_rdata;
                end
            end

            assign line_rdata[gi*BURST_WIDTH +: BURST_WIDTH] = slot_reg;
            assign wbeat[gi] = wdata_reg[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    // Every burst-side output is a decode of registered state.
    assign burst_read    = (state_reg == S_RD_BURST);
    assign burst_write   = (state_reg == S_WR_BURST);
    assign line_resp     = (state_reg == S_RESP);
    assign burst_address = addr_reg;
    assign burst_wdata   = wbeat[cnt_reg];

    logic unused_in_burst;
    assign unused_in_burst = in_burst;

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_cmp = 0;
    int n_err = 0;

    line_burst_adaptor #(
        .LINE_WIDTH (256),
        .BURST_WIDTH(64),
        .OFFSET_BITS(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full read transaction with beats on consecutive cycles; request is
    // presented in cycle 0 and line_resp is required in cycle 5.
    task automatic run_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        line_address = addr;
        line_read    = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check({tag, "_rd_strobe"}, {255'd0, burst_read}, 256'd1);
            check({tag, "_rd_noresp"}, {255'd0, line_resp}, 256'd0);
            check({tag, "_rd_addr"}, {224'd0, burst_address}, {224'd0, exp_addr});
            burst_resp  = 1'b1;
            burst_rdata = beats[k];
            tick();
        end
        burst_resp  = 1'b0;
        burst_rdata = '0;
        check({tag, "_resp_c5"}, {255'd0, line_resp}, 256'd1);
        check({tag, "_rd_off"}, {255'd0, burst_read}, 256'd0);
        check({tag, "_rdata"}, line_rdata, {b3, b2, b1, b0});
        line_read = 1'b0;
        tick();
        check({tag, "_resp_pulse"}, {255'd0, line_resp}, 256'd0);
        check({tag, "_rdata_hold"}, line_rdata, {b3, b2, b1, b0});
    endtask

    logic [63:0] wb [4];
    int          wpat [7];
    int          wexp [7];

    initial begin
        rst          = 1'b0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_address = '0;
        line_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;

        // Reset state
        #3;
        check("rst_rdata", line_rdata, 256'd0);
        check("rst_outs", {250'd0, line_resp, burst_read, burst_write, 3'd0}, 256'd0);
        check("rst_addr", {224'd0, burst_address}, 256'd0);
        check("rst_wdata", {192'd0, burst_wdata}, 256'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        tick();

        // Read, no stalls
        run_read("rd", 32'h0000_1234, 32'h0000_1220,
                 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

        // Write with stalls: resp pattern 1,0,0,1,1,0,1
        for (int k = 0; k < 4; k++) wb[k] = {8{8'hA0 + 8'(k)}};
        wpat = '{1, 0, 0, 1, 1, 0, 1};
        wexp = '{0, 1, 1, 1, 2, 3, 3};
        line_address = 32'h0000_2345;
        line_wdata   = {wb[3], wb[2], wb[1], wb[0]};
        line_write   = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            check("wr_beat", {192'd0, burst_wdata}, {192'd0, wb[wexp[i]]});
            check("wr_strobe", {254'd0, burst_write, burst_read}, 256'd2);
            check("wr_noresp", {255'd0, line_resp}, 256'd0);
            burst_resp = (wpat[i] != 0);
            tick();
        end
        burst_resp = 1'b0;
        check("wr_resp_c8", {255'd0, line_resp}, 256'd1);
        check("wr_off", {254'd0, burst_write, burst_read}, 256'd0);
        check("wr_addr", {224'd0, burst_address}, {224'd0, 32'h0000_2340});
        line_write = 1'b0;
        tick();
        check("wr_resp_pulse", {255'd0, line_resp}, 256'd0);

        // Simultaneous read + write: read wins, write line not latched
        line_address = 32'h0000_0040;
        line_wdata   = {256{1'b1}};
        line_read    = 1'b1;
        line_write   = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("both_strobe", {254'd0, burst_write, burst_read}, 256'd1);
            check("both_old_wdata", {192'd0, burst_wdata}, {192'd0, wb[k]});
            burst_resp  = 1'b1;
            burst_rdata = {16{4'h5 + 4'(k)}};
            tick();
        end
        burst_resp = 1'b0;
        check("both_resp", {255'd0, line_resp}, 256'd1);
        check("both_rdata", line_rdata,
              {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        line_read  = 1'b0;
        line_write = 1'b0;
        tick();

        // Address change mid-burst
        line_address = 32'h8000_4567;
        line_read    = 1'b1;
        tick();
        line_address = 32'hFFFF_FFE0;
        for (int k = 0; k < 4; k++) begin
            check("addr_hold", {224'd0, burst_address}, {224'd0, 32'h8000_4560});
            burst_resp  = 1'b1;
            burst_rdata = {8{8'h10 + 8'(k)}};
            tick();
        end
        burst_resp = 1'b0;
        check("addr_resp", {255'd0, line_resp}, 256'd1);
        line_read = 1'b0;
        tick();

        // Reset after two beats
        line_address = 32'h0000_0100;
        line_read    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            burst_resp  = 1'b1;
            burst_rdata = {8{8'hC0 + 8'(k)}};
            tick();
        end
        burst_resp = 1'b0;
        line_read  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_outs", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
        check("arst_addr", {224'd0, burst_address}, 256'd0);
        check("arst_rdata", line_rdata, 256'd0);
        check("arst_wdata", {192'd0, burst_wdata}, 256'd0);
        repeat (2) begin
            tick();
            check("arst_noresp", {255'd0, line_resp}, 256'd0);
        end
        #2 rst = 1'b1;
        tick();
        check("arst_idle", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
        run_read("post_rst", 32'h0000_0ABC, 32'h0000_0AA0,
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);

        // Spurious burst_resp in IDLE
        burst_resp  = 1'b1;
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) begin
            tick();
            check("spur_idle", {253'd0, line_resp, burst_read, burst_write}, 256'd0);
        end
        burst_resp = 1'b0;
        tick();
        run_read("spur", 32'h1234_567F, 32'h1234_5660,
                 64'hE0E0_E0E0_E0E0_E0E0, 64'hE1E1_E1E1_E1E1_E1E1,
                 64'hE2E2_E2E2_E2E2_E2E2, 64'hE3E3_E3E3_E3E3_E3E3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
